gate_check_seq: RTL and testbench
=================================

GATE_CHECK_SEQ -- requirements
Module: gate_check_seq

Interface
REQ-001 Parameter PAT_W, default 2: number of gate inputs driven; patterns run from 0 to 2^PAT_W-1.
REQ-002 Parameter SETTLE_CYCLES, default 1, legal range 1..15: wait cycles between applying a pattern and sampling it.
REQ-003 Parameter ERR_W, default 4: width of the mismatch counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  run request; sampled only in IDLE.
REQ-007 abort  input  1  cancels a run in progress.
REQ-008 dut_s  input  1  output of the gate under test.
REQ-009 ref_s  input  1  output of the control/reference model.
REQ-010 x_out  output  PAT_W  stimulus vector driven to both the DUT and the reference model.
REQ-011 busy  output  1  high in every state except IDLE and DONE.
REQ-012 done  output  1  single-cycle pulse on run completion.
REQ-013 pass  output  1  high when the last completed run had zero mismatches; held until the next start.
REQ-014 err_cnt  output  ERR_W  mismatch count of the current or last run.
REQ-015 fail_valid  output  1  high once a mismatch has been recorded in the current or last run.
REQ-016 fail_pat  output  PAT_W  first pattern that mismatched; meaningful only while fail_valid=1.

Function
REQ-017 The FSM SHALL use the states IDLE, APPLY, SETTLE, COMPARE and DONE.
REQ-018 IDLE with start=1 SHALL move to APPLY and, on the same edge, clear pat, err_cnt, fail_valid and pass.
REQ-019 APPLY SHALL drive x_out=pat for one cycle and then move to SETTLE.
REQ-020 SETTLE SHALL last exactly SETTLE_CYCLES cycles, hold x_out, and then move to COMPARE.
REQ-021 COMPARE SHALL sample dut_s and ref_s; when they differ, err_cnt SHALL increment, saturating at 2^ERR_W-1.
REQ-022 The first mismatch of a run SHALL latch fail_pat=pat and set fail_valid; later mismatches SHALL NOT change fail_pat.
REQ-023 From COMPARE, the FSM SHALL move to DONE when pat=2^PAT_W-1; otherwise pat SHALL increment and the FSM SHALL move to APPLY.
REQ-024 DONE SHALL assert done for exactly one cycle, set pass=(err_cnt==0), and move to IDLE.
REQ-025 done SHALL rise (2+SETTLE_CYCLES)*2^PAT_W+1 cycles after the edge that accepts start; with the defaults this is 13 cycles.
REQ-026 x_out SHALL be 0 in IDLE and DONE.
REQ-027 start asserted while busy=1 or in DONE SHALL be ignored; start held high SHALL begin a new run from IDLE.
REQ-028 abort=1 in APPLY, SETTLE or COMPARE SHALL force IDLE on the next edge; done SHALL NOT pulse, pass SHALL stay 0, and err_cnt/fail_* SHALL keep their values.
REQ-029 abort SHALL take priority over a COMPARE result in the same cycle; the sample in that cycle SHALL NOT be counted.
REQ-030 abort in IDLE or DONE SHALL have no effect.

Reset
REQ-031 reset_n=0 SHALL immediately force IDLE and x_out=0, busy=0, done=0, pass=0, err_cnt=0, fail_valid=0 and fail_pat=0, regardless of clk.
REQ-032 Reset deassertion in the middle of a run SHALL leave the block in IDLE; it SHALL NOT resume the run.

Structure
REQ-033 The state encoding and the SETTLE_CYCLES legal-range limit SHALL live in a shared package, gate_check_pkg.
REQ-034 The settle wait SHALL be a sub-module, settle_timer (load, count down, expire pulse), instantiated once.
REQ-035 The DUT and the reference model SHALL remain outside this block and connect through x_out, dut_s and ref_s.

Verification
REQ-036 Matching DUT (dut_s=ref_s=x0&x1), start pulse -> x_out steps through 00,01,10,11; done rises 13 cycles after start; pass=1; err_cnt=0; fail_valid=0.
REQ-037 DUT stuck at 1, reference is AND -> err_cnt=3; fail_pat=00; fail_valid=1; pass=0.
REQ-038 abort=1 during SETTLE of pattern 10 -> IDLE on the next edge; busy=0; x_out=00; no done pulse.
REQ-039 reset_n pulled low during COMPARE, between clock edges -> all outputs 0 at once; IDLE after release.
REQ-040 start held high for two runs, with a DUT that fails only the first run -> second run clears err_cnt and ends pass=1; start pulses during busy are ignored.
REQ-041 ERR_W=1 with 3 mismatches -> err_cnt saturates at 1; pass=0.

Source files
------------

// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate checking sequencer: FSM encoding and
// the legal bounds of the settle wait.
package gate_check_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_APPLY   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_COMPARE = 3'd3,
      ST_DONE    = 3'd4
   } state_e;

   localparam int SETTLE_MIN = 1;
   localparam int SETTLE_MAX = 15;
   localparam int SETTLE_W   = 4;

endpackage

// File: rtl/settle_timer.sv
// Down-counter for the settle wait: load a count, decrement while enabled,
// pulse expire during the last enabled cycle.
module settle_timer
   import gate_check_pkg::*;
(
   input  logic                clk,
   input  logic                reset_n,
   input  logic                load,
   input  logic                en,
   input  logic [SETTLE_W-1:0] load_val,
   output logic                expire
);

   logic [SETTLE_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (en && cnt_q != '0)
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign expire = en && !load && (cnt_q == SETTLE_W'(1));

endmodule

// File: rtl/gate_check_seq.sv
// Exhaustive gate checker: walks every input pattern, waits for the gate and
// its reference to settle, and counts the patterns where they disagree.
module gate_check_seq
   import gate_check_pkg::*;
#(
   parameter int PAT_W         = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter int ERR_W         = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic             dut_s,
   input  logic             ref_s,
   output logic [PAT_W-1:0] x_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt,
   output logic             fail_valid,
   output logic [PAT_W-1:0] fail_pat
);

   localparam logic [PAT_W-1:0] PAT_LAST = '1;
   localparam logic [ERR_W-1:0] ERR_MAX  = '1;

   if (SETTLE_CYCLES < SETTLE_MIN || SETTLE_CYCLES > SETTLE_MAX) begin : g_bad_settle
      $error("gate_check_seq: SETTLE_CYCLES out of range");
   end

   state_e             state_q, state_d;
   logic [PAT_W-1:0]   pat_q, pat_d, fail_pat_q, fail_pat_d;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               fail_valid_q, fail_valid_d;
   logic               pass_q, pass_d, done_q, done_d;
   logic               settle_load, settle_en, settle_exp;

   settle_timer u_settle (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (settle_load),
      .en       (settle_en),
      .load_val (SETTLE_W'(SETTLE_CYCLES)),
      .expire   (settle_exp)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (start) state_d = ST_APPLY;
         ST_APPLY:   state_d = abort ? ST_IDLE : ST_SETTLE;
         ST_SETTLE:  if (abort) state_d = ST_IDLE;
                     else if (settle_exp) state_d = ST_COMPARE;
         ST_COMPARE: if (abort) state_d = ST_IDLE;
                     else if (pat_q == PAT_LAST) state_d = ST_DONE;
                     else state_d = ST_APPLY;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy        = 1'b0;
      x_out       = '0;
      settle_load = 1'b0;
      settle_en   = 1'b0;
      case (state_q)
         ST_APPLY:   begin busy = 1'b1; x_out = pat_q; settle_load = 1'b1; end
         ST_SETTLE:  begin busy = 1'b1; x_out = pat_q; settle_en = 1'b1; end
         ST_COMPARE: begin busy = 1'b1; x_out = pat_q; end
         default:    ;
      endcase
   end

   // An abort in COMPARE discards that cycle's sample; results are otherwise kept.
   always_comb begin
      pat_d        = pat_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_pat_d   = fail_pat_q;
      pass_d       = pass_q;
      done_d       = (state_q == ST_DONE);
      case (state_q)
         ST_IDLE: if (start) begin
            pat_d        = '0;
            err_d        = '0;
            fail_valid_d = 1'b0;
            pass_d       = 1'b0;
         end
         ST_COMPARE: if (!abort) begin
            if (dut_s != ref_s) begin
               if (err_q != ERR_MAX) err_d = err_q + 1'b1;
               if (!fail_valid_q) begin
                  fail_valid_d = 1'b1;
                  fail_pat_d   = pat_q;
               end
            end
            if (pat_q != PAT_LAST) pat_d = pat_q + 1'b1;
         end
         ST_DONE: pass_d = (err_q == '0);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pat_q        <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_pat_q   <= '0;
         pass_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         pat_q        <= pat_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_pat_q   <= fail_pat_d;
         pass_q       <= pass_d;
         done_q       <= done_d;
      end
   end

   assign done       = done_q;
   assign pass       = pass_q;
   assign err_cnt    = err_q;
   assign fail_valid = fail_valid_q;
   assign fail_pat   = fail_pat_q;

endmodule

// File: tb/tb_gate_check_seq.sv
// Bench for gate_check_seq: run-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized runs.
module tb_gate_check_seq;

   localparam int PW   = 2;
   localparam int S    = 1;
   localparam int T    = 2 + S;
   localparam int NP   = 1 << PW;
   localparam int L    = T * NP;
   localparam int EMAX = 15;

   logic clk = 1'b0, reset_n = 1'b1, start = 1'b0, abort = 1'b0;
   logic dut_s, ref_s, busy, done, pass, fail_valid;
   logic [PW-1:0] x_out, fail_pat;
   logic [3:0] err_cnt;
   logic [NP-1:0] dut_tt = '0, ref_tt = '0;

   logic dut_b, ref_b, busy_b, done_b, pass_b, fv_b;
   logic [PW-1:0] x_b, fp_b;
   logic [0:0] err_b;

   int n_tests = 0, n_fail = 0;

   always #5 clk = ~clk;

   assign dut_s = dut_tt[x_out];
   assign ref_s = ref_tt[x_out];
   assign dut_b = 1'b1;
   assign ref_b = &x_b;

   gate_check_seq #(.PAT_W(PW), .SETTLE_CYCLES(S), .ERR_W(4)) u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .dut_s(dut_s), .ref_s(ref_s), .x_out(x_out), .busy(busy), .done(done),
      .pass(pass), .err_cnt(err_cnt), .fail_valid(fail_valid), .fail_pat(fail_pat));

   gate_check_seq #(.PAT_W(PW), .SETTLE_CYCLES(S), .ERR_W(1)) u_sat (
      .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
      .dut_s(dut_b), .ref_s(ref_b), .x_out(x_b), .busy(busy_b), .done(done_b),
      .pass(pass_b), .err_cnt(err_b), .fail_valid(fv_b), .fail_pat(fp_b));

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Run model: k counts cycles since the accepting edge (0 = not running).
   // Each pattern occupies T cycles, its sample is taken in the last of them;
   // cycle L+1 is the completion cycle, done/pass appear in the cycle after.
   int k = 0, m_err = 0, m_fp = 0;
   bit m_fv = 0, m_pass = 0, m_done = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k = 0; m_err = 0; m_fv = 0; m_fp = 0; m_pass = 0; m_done = 0;
      end else begin
         m_done = 0;
         if (k == 0) begin
            if (start) begin k = 1; m_err = 0; m_fv = 0; m_pass = 0; end
         end else if (k <= L) begin
            if (abort) k = 0;
            else begin
               if (k % T == 0 && dut_tt[k/T-1] != ref_tt[k/T-1]) begin
                  if (m_err < EMAX) m_err++;
                  if (!m_fv) begin m_fv = 1; m_fp = k / T - 1; end
               end
               k++;
            end
         end else begin
            k = 0; m_done = 1; m_pass = (m_err == 0);
         end
      end
   end

   always @(negedge clk) begin : compare
      logic eb;
      eb = (k >= 1 && k <= L);
      chk("busy", busy, eb);
      chk("x_out", x_out, eb ? (k - 1) / T : 0);
      chk("done", done, m_done);
      chk("pass", pass, m_pass);
      chk("err_cnt", err_cnt, m_err);
      chk("fail_valid", fail_valid, m_fv);
      if (m_fv) chk("fail_pat", fail_pat, m_fp);
   end

   // Returns at 1 time unit after the edge where done is seen high.
   task automatic wait_done(input int maxc, output int cyc, output logic [7:0] seq);
      logic [PW-1:0] prev;
      bit first;
      first = 1; prev = '0; seq = '0; cyc = 0;
      while (cyc < maxc && !done) begin
         @(posedge clk); #1;
         cyc++;
         if (busy && (first || x_out != prev)) begin
            seq = {seq[5:0], x_out}; prev = x_out; first = 0;
         end
      end
      if (!done) chk("done_timeout", 0, 1);
   endtask

   task automatic launch();
      @(posedge clk); #2 start = 1'b1;
      @(posedge clk); #2 start = 1'b0;
   endtask

   initial begin : stim
      int lat, cnt, ab_c;
      logic [7:0] seq;
      bit saw;

      #1 reset_n = 1'b0;
      #3;
      chk("rst_x", x_out, 0);      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);    chk("rst_pass", pass, 0);
      chk("rst_err", err_cnt, 0);  chk("rst_fv", fail_valid, 0);
      chk("rst_fp", fail_pat, 0);  chk("rst_b", {x_b, busy_b, done_b}, 0);
      @(posedge clk); #2 reset_n = 1'b1;

      // matching AND gate
      dut_tt = 4'b1000; ref_tt = 4'b1000;
      launch();
      wait_done(40, lat, seq);
      chk("latency", lat, 13);
      chk("x_seq", seq, 8'h1B);
      chk("t1_pass", pass, 1);
      chk("t1_err", err_cnt, 0);
      chk("t1_fv", fail_valid, 0);
      chk("sat_err", err_b, 1);
      chk("sat_pass", pass_b, 0);
      chk("sat_fv", fv_b, 1);
      chk("sat_fp", fp_b, 0);

      // gate stuck at 1
      dut_tt = 4'b1111;
      launch();
      wait_done(40, lat, seq);
      chk("t2_latency", lat, 13);
      chk("t2_err", err_cnt, 3);
      chk("t2_fp", fail_pat, 0);
      chk("t2_fv", fail_valid, 1);
      chk("t2_pass", pass, 0);

      // abort during SETTLE of pattern 2 (run cycle 8)
      launch();
      repeat (7) @(posedge clk);
      #2;
      chk("pre_abort_x", x_out, 2);
      abort = 1'b1;
      @(posedge clk); #1;
      chk("abort_busy", busy, 0);
      chk("abort_x", x_out, 0);
      chk("abort_err_keep", err_cnt, 2);
      #1 abort = 1'b0;
      saw = 0;
      repeat (20) begin @(posedge clk); #1; if (done) saw = 1; end
      chk("abort_no_done", saw, 0);
      chk("abort_pass", pass, 0);

      // reset between edges during COMPARE of pattern 0
      launch();
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_out", {x_out, busy, done, pass, err_cnt, fail_valid, fail_pat}, 0);
      @(posedge clk); #2 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 chk("idle_after_rst", busy, 0);

      // start held: first run fails, second run passes
      @(posedge clk); #2 start = 1'b1;
      wait_done(40, lat, seq);
      chk("run1_pass", pass, 0);
      chk("run1_err", err_cnt, 3);
      dut_tt = 4'b1000;
      @(posedge clk); #1;
      wait_done(40, lat, seq);
      start = 1'b0;
      chk("run2_pass", pass, 1);
      chk("run2_err", err_cnt, 0);
      chk("run2_fv", fail_valid, 0);

      // randomized runs with stray start/abort pulses
      for (int r = 0; r < 40; r++) begin
         @(posedge clk); #2;
         dut_tt = NP'($urandom);
         ref_tt = NP'($urandom);
         ab_c = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, L + 2)) : -1;
         start = 1'b1;
         for (int c = 0; c < L + 3; c++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) == 0);
            abort = (c == ab_c) || ($urandom_range(0, 15) == 0);
         end
         start = 1'b0; abort = 1'b0;
         cnt = 0;
         while (k != 0 && cnt < 3 * L) begin @(posedge clk); #2; cnt++; end
         chk("rand_drain", busy, 0);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
